smvm_result_collector: RTL and testbench
========================================

// Module: smvm_result_collector
// PURPOSE
//   Downstream stage of the sparse matrix-vector multiplier. Captures the 14-bit
//   row results it emits on out_valid/data_out (no backpressure available),
//   tags each with its row index, buffers them in a FIFO and re-issues them on a
//   valid/ready stream. Flags lost or unexpected results and pulses done when
//   every row of the current job has been delivered.
// PARAMETERS
//   DW     14  result width (matches multiplier data_out)
//   DEPTH  16  FIFO entries; power of two
//   AW     4   log2(DEPTH)
//   RW     8   row-index / row-count width
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      job start pulse; sampled only in IDLE
//   num_rows   in   RW     rows expected this job; latched on accepted start
//   res_valid  in   1      result strobe from multiplier (out_valid)
//   res_data   in   DW     result value, two's complement (data_out)
//   m_valid    out  1      output entry available
//   m_ready    in   1      consumer accepts entry
//   m_data     out  DW     result at FIFO head
//   m_row      out  RW     row index of head entry (0-based)
//   m_last     out  1      head entry is row num_rows-1
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse: job fully delivered
//   overflow   out  1      sticky: result dropped because FIFO full
//   stray      out  1      sticky: res_valid seen outside COLLECT
//   level      out  AW+1   current FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//   Reset: state IDLE; FIFO empty; row counter 0; m_valid, m_data, m_row,
//     m_last, busy, done, overflow, stray, level all 0. Reset mid-job discards
//     all buffered data.
//   FSM: IDLE -> COLLECT on start && num_rows!=0 (latch num_rows, clear row
//     counter, overflow, stray). start && num_rows==0: done pulses next cycle,
//     stays IDLE, flags cleared. start outside IDLE ignored.
//   COLLECT: each res_valid pushes {row_cnt, res_data, row_cnt==num_rows-1};
//     row_cnt increments on every res_valid, pushed or dropped. When the
//     strobe with row_cnt==num_rows-1 arrives -> DRAIN next cycle.
//   DRAIN -> IDLE when FIFO is empty (incl. emptied by a pop this cycle);
//     done pulses on the cycle after that transition's last pop, i.e. done
//     registered, high exactly one cycle while state returns to IDLE.
//   res_valid in IDLE or DRAIN: no push, stray <= 1.
//   FIFO: first-word fall-through; m_valid = level!=0; outputs driven straight
//     from head register/memory, stable while m_valid && !m_ready.
//     Pop when m_valid && m_ready. Push-to-m_valid latency: 1 cycle.
//   Full: push dropped and overflow <= 1, unless a pop occurs the same cycle,
//     in which case push is accepted (level stays DEPTH).
//   Empty + push same cycle: no pop (m_valid low); entry visible next cycle.
//   Pointers wrap modulo DEPTH; level never exceeds DEPTH nor underflows.
//   Data passed unmodified; no sign extension or saturation.
//   overflow/stray clear only on accepted start or reset.
// TESTING
//   start, num_rows=3; res_data 5,-2,100 on consecutive cycles, m_ready=1 ->
//     m_data 5,0x3FFE,100, m_row 0,1,2, m_last only on row 2, done 1 cycle.
//   num_rows=20, m_ready=0, 20 back-to-back strobes -> level=16, overflow=1,
//     rows 16..19 lost; drain shows rows 0..15, no m_last, done after last pop.
//   Full FIFO, m_ready=1 and res_valid same cycle -> push accepted, level=16,
//     overflow stays 0.
//   res_valid while IDLE -> no m_valid, stray=1; next start clears stray.
//   start with num_rows=0 -> done pulse next cycle, busy never asserts.
//   Assert rst_n low mid-COLLECT with level=5 -> all outputs 0, level=0,
//     state IDLE; subsequent job runs normally.

Source files
------------

// File: rtl/smvm_result_collector.sv
// Purpose: tags multiplier row results with their row index, buffers them and re-issues them on a valid/ready stream.
// Latency: a captured result appears at the head one cycle after its strobe (first-word fall-through).
// Backpressure: none upstream; results arriving while the FIFO is full with no pop are dropped and flagged.
module smvm_result_collector #(
    parameter int DW    = 14,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int RW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [RW-1:0] num_rows,
    input  logic          res_valid,
    input  logic [DW-1:0] res_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [RW-1:0] m_row,
    output logic          m_last,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          stray,
    output logic [AW:0]   level
);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    typedef struct packed {
        logic [RW-1:0] row;
        logic [DW-1:0] data;
        logic          last;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic [RW-1:0] rows_q;
    logic [RW-1:0] row_cnt;
    logic          done_q;
    logic          overflow_q;
    logic          stray_q;

    logic full;
    logic pop;
    logic push_req;
    logic push;
    logic is_last;

    always_comb begin
        full     = (level_q == (AW+1)'(DEPTH));
        pop      = (level_q != '0) && m_ready;
        push_req = (state == COLLECT) && res_valid;
        // A full FIFO still takes the push when the head leaves the same cycle.
        push     = push_req && (!full || pop);
        is_last  = (row_cnt == RW'(rows_q - RW'(1)));
        head     = mem[rd_ptr];
    end

    // Payload storage carries no reset; empty-state outputs are masked below.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{row: row_cnt, data: res_data, last: is_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            rows_q     <= '0;
            row_cnt    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        overflow_q <= 1'b0;
                        stray_q    <= 1'b0;
                        if (num_rows != '0) begin
                            rows_q  <= num_rows;
                            row_cnt <= '0;
                            state   <= COLLECT;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (res_valid) begin
                        row_cnt <= row_cnt + RW'(1);
                        if (is_last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (level_q == '0 || (level_q == (AW+1)'(1) && pop)) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push_req && full && !pop) overflow_q <= 1'b1;
            // Flag set after the start clear so a strobe coincident with start is still reported.
            if (res_valid && state != COLLECT) stray_q <= 1'b1;
        end
    end

    always_comb begin
        m_valid  = (level_q != '0);
        m_data   = m_valid ? head.data : '0;
        m_row    = m_valid ? head.row  : '0;
        m_last   = m_valid && head.last;
        busy     = (state != IDLE);
        done     = done_q;
        overflow = overflow_q;
        stray    = stray_q;
        level    = level_q;
    end

endmodule

// File: tb/tb_smvm_result_collector.sv
// Directed bench for smvm_result_collector: inputs change 1 time unit after each rising edge,
// outputs are sampled at the same point, so every check sees the state registered by that edge.
module tb_smvm_result_collector;

    localparam int DW = 14;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int RW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [RW-1:0] num_rows;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [RW-1:0] m_row;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          stray;
    logic [AW:0]   level;

    int checks = 0;
    int errors = 0;

    smvm_result_collector #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .RW(RW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_rows (num_rows),
        .res_valid(res_valid),
        .res_data (res_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_row    (m_row),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .stray    (stray),
        .level    (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_m_valid"},  32'(m_valid),  32'd0);
        chk({tag, "_m_data"},   32'(m_data),   32'd0);
        chk({tag, "_m_row"},    32'(m_row),    32'd0);
        chk({tag, "_m_last"},   32'(m_last),   32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_stray"},    32'(stray),    32'd0);
        chk({tag, "_level"},    32'(level),    32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_rows  = '0;
        res_valid = 1'b0;
        res_data  = '0;
        m_ready   = 1'b0;
        #12;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Job of 3 rows streamed straight through with the consumer always ready.
        start = 1'b1; num_rows = 8'd3;
        tick();
        start = 1'b0;
        chk("j3_busy", 32'(busy), 32'd1);
        m_ready = 1'b1;
        res_valid = 1'b1; res_data = 14'd5;
        tick();
        chk("j3_r0_data", 32'(m_data), 32'd5);
        chk("j3_r0_row",  32'(m_row),  32'd0);
        chk("j3_r0_last", 32'(m_last), 32'd0);
        res_data = 14'h3FFE;
        tick();
        chk("j3_r1_data", 32'(m_data), 32'h3FFE);
        chk("j3_r1_row",  32'(m_row),  32'd1);
        chk("j3_r1_last", 32'(m_last), 32'd0);
        chk("j3_r1_lvl",  32'(level),  32'd1);
        res_data = 14'd100;
        tick();
        chk("j3_r2_data", 32'(m_data), 32'd100);
        chk("j3_r2_row",  32'(m_row),  32'd2);
        chk("j3_r2_last", 32'(m_last), 32'd1);
        chk("j3_r2_done", 32'(done),   32'd0);
        res_valid = 1'b0;
        tick();
        chk("j3_done",  32'(done),    32'd1);
        chk("j3_idle",  32'(busy),    32'd0);
        chk("j3_empty", 32'(m_valid), 32'd0);
        tick();
        chk("j3_done_pulse", 32'(done), 32'd0);
        chk("j3_no_ovf", 32'(overflow), 32'd0);

        // 20 back-to-back results into a stalled 16-entry FIFO: rows 16..19 are lost.
        m_ready = 1'b0;
        start = 1'b1; num_rows = 8'd20;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            res_valid = 1'b1; res_data = 14'(i + 10);
            tick();
        end
        res_valid = 1'b0;
        chk("ovf_level", 32'(level),    32'd16);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_busy",  32'(busy),     32'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_row%0d", i),  32'(m_row),  32'(i));
            chk($sformatf("ovf_data%0d", i), 32'(m_data), 32'(i + 10));
            chk($sformatf("ovf_last%0d", i), 32'(m_last), 32'd0);
            chk($sformatf("ovf_done%0d", i), 32'(done),   32'd0);
            tick();
        end
        chk("ovf_done",     32'(done),     32'd1);
        chk("ovf_idle",     32'(busy),     32'd0);
        chk("ovf_empty",    32'(level),    32'd0);
        chk("ovf_sticky",   32'(overflow), 32'd1);
        m_ready = 1'b0;
        tick();

        // Full FIFO with a simultaneous pop still accepts the final push.
        start = 1'b1; num_rows = 8'd17;
        tick();
        start = 1'b0;
        chk("full_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            res_valid = 1'b1; res_data = 14'(i);
            tick();
        end
        chk("full_level16", 32'(level), 32'd16);
        res_data = 14'h123; m_ready = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("full_pp_level", 32'(level),    32'd16);
        chk("full_pp_ovf",   32'(overflow), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("full_row%0d", i),  32'(m_row),  32'(i));
            chk($sformatf("full_data%0d", i), 32'(m_data), (i == 16) ? 32'h123 : 32'(i));
            chk($sformatf("full_last%0d", i), 32'(m_last), (i == 16) ? 32'd1 : 32'd0);
            tick();
        end
        chk("full_done", 32'(done), 32'd1);
        m_ready = 1'b0;
        tick();

        // Result strobe while idle is flagged and never buffered.
        res_valid = 1'b1; res_data = 14'd77;
        tick();
        res_valid = 1'b0;
        chk("stray_flag",   32'(stray),   32'd1);
        chk("stray_nvalid", 32'(m_valid), 32'd0);
        chk("stray_level",  32'(level),   32'd0);

        // Zero-row job: immediate done, flags cleared, never busy.
        start = 1'b1; num_rows = 8'd0;
        tick();
        start = 1'b0;
        chk("zero_done",  32'(done),  32'd1);
        chk("zero_busy",  32'(busy),  32'd0);
        chk("zero_stray", 32'(stray), 32'd0);
        tick();
        chk("zero_done_pulse", 32'(done), 32'd0);
        chk("zero_busy2",      32'(busy), 32'd0);

        // Reset mid-collection discards buffered results.
        start = 1'b1; num_rows = 8'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            res_valid = 1'b1; res_data = 14'(i + 40);
            tick();
        end
        res_valid = 1'b0;
        chk("mid_level5", 32'(level), 32'd5);
        rst_n = 1'b0;
        #2;
        chk_idle_outputs("midrst");
        rst_n = 1'b1;
        tick();

        start = 1'b1; num_rows = 8'd2;
        tick();
        start = 1'b0;
        m_ready = 1'b1;
        res_valid = 1'b1; res_data = 14'd7;
        tick();
        chk("post_r0_data", 32'(m_data), 32'd7);
        chk("post_r0_row",  32'(m_row),  32'd0);
        chk("post_r0_last", 32'(m_last), 32'd0);
        res_data = 14'd8;
        tick();
        res_valid = 1'b0;
        chk("post_r1_data", 32'(m_data), 32'd8);
        chk("post_r1_row",  32'(m_row),  32'd1);
        chk("post_r1_last", 32'(m_last), 32'd1);
        tick();
        chk("post_done",  32'(done),  32'd1);
        chk("post_level", 32'(level), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
